// File: rtl/audio_rec_pkg.sv
// audio_rec_pkg: shared types, widths and helpers for the audio RAM sequencer
package audio_rec_pkg;
    localparam int ADDR_W = 26;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 26'd1;
    typedef enum logic [2:0] {IDLE, REC, PLAY_IDLE, PLAY_WAIT, PLAY_ACK} state_t;
    function automatic int sample_w(input int bytes);
        return 8 * bytes;
    endfunction
endpackage

// File: rtl/audio_addr_ptr.sv
// audio_addr_ptr: address counter with sync clear, increment and terminal compare
module audio_addr_ptr
    import audio_rec_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] term_val,
    output logic [ADDR_W-1:0] cnt,
    output logic [ADDR_W-1:0] nxt,
    output logic              at_term
);
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    // next count: clear has priority over increment
    always_comb begin
        nxt     = cnt_q + ADDR_ONE;
        cnt_d   = clr ? '0 : inc ? nxt : cnt_q;
        cnt     = cnt_q;
        at_term = cnt_q == term_val;
    end
    // count register
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/audio_ram_sequencer.sv
// audio_ram_sequencer: record/playback controller for the DDR RAM wrapper; LOOP_PLAYBACK_EN enables looped playback
module audio_ram_sequencer
    import audio_rec_pkg::*;
#(
    parameter int DATA_BYTE_WIDTH = 1,
    localparam int W = sample_w(DATA_BYTE_WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic [W-1:0]      sample_in,
    input  logic              sample_in_valid,
    input  logic              sample_tick,
    output logic [W-1:0]      sample_out,
    output logic              sample_out_valid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [W-1:0]      ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_request,
    output logic              ram_read_ack,
    input  logic [W-1:0]      ram_data_out,
    input  logic              ram_rdy,
    input  logic              ram_rd_data_pres,
    input  logic [ADDR_W-1:0] max_ram_address,
    output logic              recording,
    output logic              playing,
    output logic [ADDR_W-1:0] rec_length,
    output logic              mem_full,
    output logic              overrun
);
`ifdef LOOP_PLAYBACK_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif
    state_t state_q, state_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d, rec_length_q, rec_length_d;
    logic [W-1:0] ram_data_in_q, ram_data_in_d, sample_out_q, sample_out_d;
    logic we_q, we_d, rr_q, rr_d, ack_q, ack_d, sov_q, sov_d;
    logic mem_full_q, mem_full_d, overrun_q, overrun_d, stop_pend_q, stop_pend_d;
    logic [ADDR_W-1:0] wr_cnt, wr_nxt, rd_cnt, rd_nxt;
    logic wr_term, rd_term, wr_clr, wr_inc, play_go, rd_clr, req, in_ack, stopping;
    // command decode shared by the FSM and the datapath
    always_comb begin
        wr_clr   = state_q == IDLE && ram_rdy && rec_start;
        play_go  = state_q == IDLE && ram_rdy && !rec_start && play_start && rec_length_q != '0;
        wr_inc   = state_q == REC && sample_in_valid;
        req      = state_q == PLAY_IDLE && sample_tick && !stop;
        in_ack   = state_q == PLAY_ACK;
        stopping = stop_pend_q || stop;
        rd_clr   = play_go || (LOOP_EN && in_ack && rd_term && !stopping);
    end
    audio_addr_ptr u_wr_ptr (
        .clk(clk), .reset(reset), .clr(wr_clr), .inc(wr_inc), .term_val(max_ram_address),
        .cnt(wr_cnt), .nxt(wr_nxt), .at_term(wr_term)
    );
    audio_addr_ptr u_rd_ptr (
        .clk(clk), .reset(reset), .clr(rd_clr), .inc(in_ack), .term_val(rec_length_q - ADDR_ONE),
        .cnt(rd_cnt), .nxt(rd_nxt), .at_term(rd_term)
    );
    // state register
    always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
    // next-state logic; a pending stop always drains the outstanding read first
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = wr_clr ? REC : play_go ? PLAY_IDLE : IDLE;
            REC:       state_d = (stop || (wr_inc && wr_term)) ? IDLE : REC;
            PLAY_IDLE: state_d = stop ? IDLE : sample_tick ? PLAY_WAIT : PLAY_IDLE;
            PLAY_WAIT: state_d = ram_rd_data_pres ? PLAY_ACK : PLAY_WAIT;
            PLAY_ACK:  state_d = (stopping || (rd_term && !LOOP_EN)) ? IDLE : PLAY_IDLE;
            default:   state_d = IDLE;
        endcase
    end
    // registered outputs; the address only moves on a write or a new read request
    always_comb begin
        ram_address_d = wr_inc ? wr_cnt : req ? rd_cnt : ram_address_q;
        ram_data_in_d = wr_inc ? sample_in : ram_data_in_q;
        we_d          = wr_inc;
        rr_d          = req;
        ack_d         = state_q == PLAY_WAIT && ram_rd_data_pres;
        sov_d         = in_ack && !stopping;
        sample_out_d  = sov_d ? ram_data_out : sample_out_q;
        rec_length_d  = wr_clr ? '0 : wr_inc ? wr_nxt : rec_length_q;
        mem_full_d    = wr_clr ? 1'b0 : (wr_inc && wr_term) ? 1'b1 : mem_full_q;
        overrun_d     = (wr_clr || play_go) ? 1'b0 : (state_q == PLAY_WAIT && sample_tick) ? 1'b1 : overrun_q;
        stop_pend_d   = state_q == PLAY_WAIT && stopping;
    end
    // output and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_address_q <= '0;
            ram_data_in_q <= '0;
            sample_out_q  <= '0;
            rec_length_q  <= '0;
            {we_q, rr_q, ack_q, sov_q, mem_full_q, overrun_q, stop_pend_q} <= '0;
        end else begin
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
            sample_out_q  <= sample_out_d;
            rec_length_q  <= rec_length_d;
            {we_q, rr_q, ack_q, sov_q, mem_full_q, overrun_q, stop_pend_q} <=
                {we_d, rr_d, ack_d, sov_d, mem_full_d, overrun_d, stop_pend_d};
        end
    end
    assign sample_out       = sample_out_q;
    assign sample_out_valid = sov_q;
    assign ram_address      = ram_address_q;
    assign ram_data_in      = ram_data_in_q;
    assign ram_write_enable = we_q;
    assign ram_read_request = rr_q;
    assign ram_read_ack     = ack_q;
    assign recording        = state_q == REC;
    assign playing          = state_q == PLAY_IDLE || state_q == PLAY_WAIT || state_q == PLAY_ACK;
    assign rec_length       = rec_length_q;
    assign mem_full         = mem_full_q;
    assign overrun          = overrun_q;
endmodule

// File: tb/tb_audio_ram_sequencer.sv
// tb_audio_ram_sequencer: directed self-checking bench for audio_ram_sequencer
module tb_audio_ram_sequencer;
    logic clk = 0, reset = 0, rec_start = 0, play_start = 0, stop = 0;
    logic [7:0] sample_in = 0, sample_out, ram_data_in, ram_data_out = 0;
    logic sample_in_valid = 0, sample_tick = 0, sample_out_valid;
    logic [25:0] ram_address, max_ram_address = 26'd100, rec_length;
    logic ram_write_enable, ram_read_request, ram_read_ack;
    logic ram_rdy = 1, ram_rd_data_pres = 0;
    logic recording, playing, mem_full, overrun;
    int total = 0, passed = 0;
    logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    audio_ram_sequencer #(.DATA_BYTE_WIDTH(1)) dut (
        .clk(clk), .reset(reset), .rec_start(rec_start), .play_start(play_start), .stop(stop),
        .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_tick(sample_tick),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_write_enable(ram_write_enable),
        .ram_read_request(ram_read_request), .ram_read_ack(ram_read_ack),
        .ram_data_out(ram_data_out), .ram_rdy(ram_rdy), .ram_rd_data_pres(ram_rd_data_pres),
        .max_ram_address(max_ram_address), .recording(recording), .playing(playing),
        .rec_length(rec_length), .mem_full(mem_full), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        reset = 0;
        total++;
        if ({sample_out, sample_out_valid, ram_address, ram_data_in, ram_write_enable, ram_read_request,
             ram_read_ack, recording, playing, rec_length, mem_full, overrun} !== '0)
            $display("FAIL reset_outputs: addr=%h len=%h rec=%b play=%b", ram_address, rec_length, recording, playing);
        else passed++;
    endtask

    task automatic test_gating();
        play_start = 1;
        step();
        play_start = 0;
        total++;
        if (playing !== 1'b0) $display("FAIL gate_len0: playing=%b want 0", playing); else passed++;
        ram_rdy = 0;
        rec_start = 1;
        step();
        rec_start = 0;
        ram_rdy = 1;
        total++;
        if (recording !== 1'b0) $display("FAIL gate_rdy_rec: recording=%b want 0", recording); else passed++;
    endtask

    task automatic test_record();
        rec_start = 1;
        play_start = 1;
        step();
        rec_start = 0;
        play_start = 0;
        total++;
        if (recording !== 1'b1 || playing !== 1'b0) $display("FAIL rec_start: rec=%b play=%b want 1 0", recording, playing); else passed++;
        for (int i = 0; i < 4; i++) begin
            sample_in = exp_data[i];
            sample_in_valid = 1;
            step();
            sample_in_valid = 0;
            total++;
            if (ram_write_enable !== 1'b1 || ram_address !== 26'(i) || ram_data_in !== exp_data[i])
                $display("FAIL rec_write%0d: we=%b addr=%0d data=%h want 1 %0d %h", i, ram_write_enable, ram_address, ram_data_in, i, exp_data[i]);
            else passed++;
            step();
            total++;
            if (ram_write_enable !== 1'b0) $display("FAIL rec_we_pulse%0d: we=%b want 0", i, ram_write_enable); else passed++;
        end
        stop = 1;
        step();
        stop = 0;
        total++;
        if (recording !== 1'b0 || rec_length !== 26'd4 || mem_full !== 1'b0)
            $display("FAIL rec_stop: rec=%b len=%0d full=%b want 0 4 0", recording, rec_length, mem_full);
        else passed++;
    endtask

    task automatic play_one(input int idx, input logic [25:0] addr, input logic [7:0] data);
        sample_tick = 1;
        step();
        sample_tick = 0;
        total++;
        if (ram_read_request !== 1'b1 || ram_address !== addr)
            $display("FAIL play_req%0d: rr=%b addr=%0d want 1 %0d", idx, ram_read_request, ram_address, addr);
        else passed++;
        step();
        total++;
        if (ram_read_request !== 1'b0 || ram_address !== addr)
            $display("FAIL play_hold%0d: rr=%b addr=%0d want 0 %0d", idx, ram_read_request, ram_address, addr);
        else passed++;
        step();
        step();
        ram_rd_data_pres = 1;
        ram_data_out = data;
        step();
        ram_rd_data_pres = 0;
        total++;
        if (ram_read_ack !== 1'b1 || ram_address !== addr || sample_out_valid !== 1'b0)
            $display("FAIL play_ack%0d: ack=%b addr=%0d sov=%b want 1 %0d 0", idx, ram_read_ack, ram_address, sample_out_valid, addr);
        else passed++;
        step();
        total++;
        if (sample_out_valid !== 1'b1 || sample_out !== data || ram_read_ack !== 1'b0)
            $display("FAIL play_out%0d: sov=%b out=%h ack=%b want 1 %h 0", idx, sample_out_valid, sample_out, ram_read_ack, data);
        else passed++;
    endtask

    task automatic test_play();
        ram_rdy = 0;
        play_start = 1;
        step();
        play_start = 0;
        ram_rdy = 1;
        total++;
        if (playing !== 1'b0) $display("FAIL gate_rdy_play: playing=%b want 0", playing); else passed++;
        play_start = 1;
        step();
        play_start = 0;
        total++;
        if (playing !== 1'b1 || overrun !== 1'b0) $display("FAIL play_start: play=%b ovr=%b want 1 0", playing, overrun); else passed++;
        for (int i = 0; i < 4; i++) play_one(i, 26'(i), exp_data[i]);
`ifdef LOOP_PLAYBACK_EN
        total++;
        if (playing !== 1'b1) $display("FAIL loop_playing: playing=%b want 1", playing); else passed++;
        play_one(4, 26'd0, 8'h11);
        stop = 1;
        step();
        stop = 0;
`endif
        total++;
        if (playing !== 1'b0 || rec_length !== 26'd4) $display("FAIL play_end: play=%b len=%0d want 0 4", playing, rec_length); else passed++;
    endtask

    task automatic test_overrun_stop();
        int acks = 0, valids = 0;
        play_start = 1;
        step();
        play_start = 0;
        sample_tick = 1;
        step();
        sample_tick = 0;
        stop = 1;
        sample_tick = 1;
        step();
        stop = 0;
        sample_tick = 0;
        total++;
        if (overrun !== 1'b1 || playing !== 1'b1) $display("FAIL ovr_set: ovr=%b play=%b want 1 1", overrun, playing); else passed++;
        ram_rd_data_pres = 1;
        ram_data_out = 8'h5a;
        step();
        ram_rd_data_pres = 0;
        for (int i = 0; i < 4; i++) begin
            acks += int'(ram_read_ack);
            valids += int'(sample_out_valid);
            step();
        end
        total++;
        if (acks != 1 || valids != 0 || playing !== 1'b0 || overrun !== 1'b1)
            $display("FAIL stop_drain: acks=%0d valids=%0d play=%b ovr=%b want 1 0 0 1", acks, valids, playing, overrun);
        else passed++;
    endtask

    task automatic test_full();
        int writes = 0;
        max_ram_address = 26'd3;
        rec_start = 1;
        step();
        rec_start = 0;
        for (int i = 0; i < 6; i++) begin
            sample_in = 8'(8'h60 + i);
            sample_in_valid = 1;
            step();
            sample_in_valid = 0;
            writes += int'(ram_write_enable);
            step();
            writes += int'(ram_write_enable);
        end
        total++;
        if (writes != 4 || mem_full !== 1'b1 || rec_length !== 26'd4 || recording !== 1'b0 || ram_address !== 26'd3)
            $display("FAIL full: writes=%0d full=%b len=%0d rec=%b addr=%0d want 4 1 4 0 3", writes, mem_full, rec_length, recording, ram_address);
        else passed++;
        max_ram_address = 26'd100;
    endtask

    task automatic test_reset_mid();
        play_start = 1;
        step();
        play_start = 0;
        sample_tick = 1;
        step();
        sample_tick = 0;
        total++;
        if (ram_read_request !== 1'b1) $display("FAIL mid_req: rr=%b want 1", ram_read_request); else passed++;
        reset = 1;
        step();
        reset = 0;
        total++;
        if ({sample_out, sample_out_valid, ram_address, ram_data_in, ram_write_enable, ram_read_request,
             ram_read_ack, recording, playing, rec_length, mem_full, overrun} !== '0)
            $display("FAIL reset_mid: addr=%h len=%h full=%b ovr=%b play=%b", ram_address, rec_length, mem_full, overrun, playing);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_gating();
        test_record();
        test_play();
        test_overrun_stop();
        test_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
